// File: rtl/qcl_pulse_stretch.sv
// Multi-channel counter-based pulse stretcher: each trigger opens a programmable-length window,
// with optional retrigger and post-window holdoff. Define QCL_PULSE_STRETCH_OVERRUN_EN for sticky overrun flags.
module qcl_pulse_stretch #(
  parameter int   els_p       = 4,
  parameter int   len_width_p = 8,
  parameter logic val_p       = 1'b1,
  parameter int   retrig_p    = 1,
  parameter int   holdoff_p   = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [els_p-1:0]       trig_i,
  input  logic [len_width_p-1:0] len_i,
  output logic [els_p-1:0]       o,
  output logic [els_p-1:0]       busy_o,
  output logic [els_p-1:0]       done_o
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
  ,
  output logic [els_p-1:0]       overrun_o
`endif
);

  localparam int hold_width = (holdoff_p > 0) ? $clog2(holdoff_p + 1) : 1;
  localparam logic [hold_width-1:0] hold_load =
    (holdoff_p > 0) ? hold_width'(holdoff_p - 1) : '0;
  localparam logic idle_val = ~val_p;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  if (els_p < 1) begin : g_els_chk
    $error("qcl_pulse_stretch: els_p must be >= 1");
  end
  if (len_width_p < 1) begin : g_len_chk
    $error("qcl_pulse_stretch: len_width_p must be >= 1");
  end
  if (holdoff_p < 0) begin : g_hold_chk
    $error("qcl_pulse_stretch: holdoff_p must be >= 0");
  end

  // Shared by all channels: a zero length never loads or reloads a window.
  logic                   len_nz;
  logic [len_width_p-1:0] len_m1;

  assign len_nz = |len_i;
  assign len_m1 = len_i - len_width_p'(1);

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    state_t                 state, state_nxt;
    logic [len_width_p-1:0] cnt, cnt_nxt;
    logic [hold_width-1:0]  hcnt, hcnt_nxt;
    logic                   done_nxt;
    logic                   o_q, busy_q, done_q;

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hcnt_nxt  = hcnt;
      done_nxt  = 1'b0;
      case (state)
        IDLE: begin
          if (trig_i[i] && len_nz) begin
            state_nxt = ACTIVE;
            cnt_nxt   = len_m1;
          end
        end
        ACTIVE: begin
          // A reload on the last count keeps the window seamless and suppresses done.
          if ((retrig_p != 0) && trig_i[i] && len_nz) begin
            cnt_nxt = len_m1;
          end else if (cnt != '0) begin
            cnt_nxt = cnt - len_width_p'(1);
          end else begin
            done_nxt = 1'b1;
            if (holdoff_p > 0) begin
              state_nxt = HOLDOFF;
              hcnt_nxt  = hold_load;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        HOLDOFF: begin
          if (hcnt != '0) begin
            hcnt_nxt = hcnt - hold_width'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they appear as plain flops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state  <= IDLE;
        cnt    <= '0;
        hcnt   <= '0;
        o_q    <= idle_val;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        hcnt   <= hcnt_nxt;
        o_q    <= (state_nxt == ACTIVE) ? val_p : idle_val;
        busy_q <= (state_nxt != IDLE);
        done_q <= done_nxt;
      end
    end

    assign o[i]      = o_q;
    assign busy_o[i] = busy_q;
    assign done_o[i] = done_q;

`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
    logic ignored;
    logic ovr_q;

    assign ignored = trig_i[i] &&
                     ((state == HOLDOFF) || ((state == ACTIVE) && (retrig_p == 0)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        ovr_q <= 1'b0;
      end else begin
        ovr_q <= ovr_q | ignored;
      end
    end

    assign overrun_o[i] = ovr_q;
`endif
  end

endmodule

// File: tb/tb_qcl_pulse_stretch.sv
// Bench for qcl_pulse_stretch: two instances (retrigger/no holdoff active-high, no retrigger/holdoff=4 active-low)
// checked every cycle against a remaining-cycles model, plus directed literal checks and random stimulus.
module tb_qcl_pulse_stretch;
  localparam int N  = 4;
  localparam int LW = 8;
  localparam int HN = 8192;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  trig  = '0;
  logic [LW-1:0] len   = '0;

  logic [N-1:0] o_d[2];
  logic [N-1:0] busy_d[2];
  logic [N-1:0] done_d[2];
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
  logic [N-1:0] ovr_d[2];
  bit           ovr_m[2][N];
`endif

  int rem[2][N];
  int hold[2][N];
  bit done_m[2][N];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  logic [N-1:0] hist_o[2][HN];
  logic [N-1:0] hist_d[2][HN];

  qcl_pulse_stretch #(.els_p(N), .len_width_p(LW), .val_p(1'b1), .retrig_p(1), .holdoff_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .trig_i(trig), .len_i(len),
    .o(o_d[0]), .busy_o(busy_d[0]), .done_o(done_d[0])
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
    , .overrun_o(ovr_d[0])
`endif
  );

  qcl_pulse_stretch #(.els_p(N), .len_width_p(LW), .val_p(1'b0), .retrig_p(0), .holdoff_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .trig_i(trig), .len_i(len),
    .o(o_d[1]), .busy_o(busy_d[1]), .done_o(done_d[1])
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
    , .overrun_o(ovr_d[1])
`endif
  );

  always #5 clk = ~clk;

  function automatic logic val_of(input int k);
    return (k == 0);
  endfunction
  function automatic bit retrig_of(input int k);
    return (k == 0);
  endfunction
  function automatic int hold_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: rem = window cycles still to show (including current), hold = holdoff cycles left.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < N; c++) begin
          rem[k][c] = 0; hold[k][c] = 0; done_m[k][c] = 0;
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
          ovr_m[k][c] = 0;
`endif
        end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < N; c++) begin
          done_m[k][c] = 0;
          if (rem[k][c] > 0) begin
            if (retrig_of(k) && trig[c] && len != 0) rem[k][c] = int'(len);
            else begin
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
              if (trig[c] && !retrig_of(k)) ovr_m[k][c] = 1;
`endif
              rem[k][c]--;
              if (rem[k][c] == 0) begin
                done_m[k][c] = 1;
                hold[k][c]   = hold_of(k);
              end
            end
          end else if (hold[k][c] > 0) begin
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
            if (trig[c]) ovr_m[k][c] = 1;
`endif
            hold[k][c]--;
          end else if (trig[c] && len != 0) begin
            rem[k][c] = int'(len);
          end
        end
    end
  end

  logic [N-1:0] eo, eb, ed;
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
  logic [N-1:0] ev;
`endif
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        eo[c] = (rem[k][c] > 0) ? val_of(k) : ~val_of(k);
        eb[c] = (rem[k][c] > 0) || (hold[k][c] > 0);
        ed[c] = done_m[k][c];
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
        ev[c] = ovr_m[k][c];
`endif
      end
      chk($sformatf("o[%0d]", k), 32'(o_d[k]), 32'(eo));
      chk($sformatf("busy[%0d]", k), 32'(busy_d[k]), 32'(eb));
      chk($sformatf("done[%0d]", k), 32'(done_d[k]), 32'(ed));
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
      chk($sformatf("overrun[%0d]", k), 32'(ovr_d[k]), 32'(ev));
`endif
      hist_o[k][cyc % HN] = o_d[k];
      hist_d[k][cyc % HN] = done_d[k];
    end
  end

  task automatic drive(input logic [N-1:0] t, input int l);
    @(posedge clk);
    #2;
    trig = t;
    len  = LW'(l);
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 0);
  endtask

  int e, r, cnt_hi;
  logic [8:0] pat;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_o_a", 32'(o_d[0]), 32'h0);
    chk("reset_o_b", 32'(o_d[1]), 32'hF);
    chk("reset_busy_a", 32'(busy_d[0]), 32'h0);
    chk("reset_done_a", 32'(done_d[0]), 32'h0);

    // Single len=5 trigger on ch0.
    drive(4'b0001, 5); e = cyc + 1;
    drive('0, 0); idle(10);
    pat = 9'b000011111;
    for (int i = 0; i < 8; i++) begin
      chk("len5_o", 32'(hist_o[0][(e + i) % HN][0]), 32'(pat[i]));
      chk("len5_done", 32'(hist_d[0][(e + i) % HN][0]), 32'(i == 5));
    end

    // Retrigger ch1 at t=0 and t=2 with len=3.
    drive(4'b0010, 3); e = cyc + 1;
    drive('0, 3); drive(4'b0010, 3); drive('0, 0); idle(10);
    for (int i = 0; i < 8; i++) begin
      chk("retrig_o", 32'(hist_o[0][(e + i) % HN][1]), 32'(pat[i]));
      chk("retrig_done", 32'(hist_d[0][(e + i) % HN][1]), 32'(i == 5));
    end

    // Held trigger on ch2, len=2: holdoff instance gives 2 active, 4 holdoff, 1 idle.
    drive(4'b0100, 2); e = cyc + 1;
    repeat (11) drive(4'b0100, 2);
    drive('0, 0); idle(15);
    pat = 9'b110000011;
    for (int i = 0; i < 9; i++)
      chk("holdoff_pat", 32'(hist_o[1][(e + i) % HN][2] == 1'b0), 32'(pat[i]));
    for (int i = 0; i < 12; i++)
      chk("held_retrig_o", 32'(hist_o[0][(e + i) % HN][2]), 32'h1);

    // len=0 triggers on all channels from idle.
    drive(4'hF, 0); e = cyc + 1;
    drive('0, 0); idle(5);
    for (int i = 0; i < 4; i++) begin
      chk("len0_o_a", 32'(hist_o[0][(e + i) % HN]), 32'h0);
      chk("len0_o_b", 32'(hist_o[1][(e + i) % HN]), 32'hF);
      chk("len0_done", 32'(hist_d[0][(e + i) % HN] | hist_d[1][(e + i) % HN]), 32'h0);
    end
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
    chk("overrun_b_lit", 32'(ovr_d[1]), 32'h6);
    chk("overrun_a_lit", 32'(ovr_d[0]), 32'h0);
`endif

    // Maximum window.
    drive(4'b1000, 255); e = cyc + 1;
    drive('0, 0); idle(265);
    cnt_hi = 0;
    for (int i = -1; i < 258; i++) cnt_hi += int'(hist_o[0][(e + i) % HN][3]);
    chk("len255_count", 32'(cnt_hi), 32'd255);
    chk("len255_last", 32'(hist_o[0][(e + 254) % HN][3]), 32'h1);
    chk("len255_done", 32'(hist_d[0][(e + 255) % HN][3]), 32'h1);

    // Staggered independent channels.
    drive(4'b0001, 3); e = cyc + 1;
    drive(4'b0010, 7); drive(4'b0100, 1); drive(4'b1000, 5);
    drive('0, 0); idle(15);
    chk("stag_done0", 32'(hist_d[0][(e + 3) % HN][0]), 32'h1);
    chk("stag_done1", 32'(hist_d[0][(e + 8) % HN][1]), 32'h1);
    chk("stag_done2", 32'(hist_d[0][(e + 3) % HN][2]), 32'h1);
    chk("stag_done3", 32'(hist_d[0][(e + 8) % HN][3]), 32'h1);
    chk("stag_end0", 32'(hist_o[0][(e + 3) % HN][0]), 32'h0);

    // Reset mid-window with cnt=3.
    drive(4'b0001, 6);
    drive('0, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_o_a", 32'(o_d[0]), 32'h0);
    chk("async_rst_busy_a", 32'(busy_d[0]), 32'h0);
    chk("async_rst_o_b", 32'(o_d[1]), 32'hF);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    r = cyc + 1;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_done", 32'(hist_d[0][(r + i) % HN] | hist_d[1][(r + i) % HN]), 32'h0);
      chk("post_rst_o", 32'(hist_o[0][(r + i) % HN]), 32'h0);
    end
`ifdef QCL_PULSE_STRETCH_OVERRUN_EN
    chk("overrun_cleared", 32'(ovr_d[1]), 32'h0);
`endif

    // Random stimulus against the model.
    for (int it = 0; it < 2500; it++) begin
      int sel;
      @(posedge clk);
      #2;
      trig = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      sel  = int'($urandom_range(0, 9));
      if (sel == 0) len = '0;
      else if (sel < 8) len = LW'($urandom_range(1, 6));
      else len = LW'($urandom_range(7, 40));
      if (it == 1300) begin
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
